multicycle_control: RTL and testbench

//  Multi-cycle control FSM for the 16-bit CPU; replaces the single-cycle opcode decoder.

---
 rtl/multicycle_control.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit CPU.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on the
// memory ready handshake. Datapath strobes are decoded from the registered
// state and latched opcode. Illegal opcodes and memory timeouts park the
// machine in a sticky HALT state that only rst_n can leave.
module multicycle_control #(
   parameter int OPCODE_W    = 3,
   parameter int ALUOP_W     = 2,
   parameter int MEM_TIMEOUT = 15,
   parameter int TMO_W       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                zero,
   output logic                ir_write,
   output logic                pc_write,
   output logic                jump,
   output logic                branch,
   output logic                mem_req,
   output logic                memwrite,
   output logic                regwrite,
   output logic                memtoreg,
   output logic                reg_dest,
   output logic                alu_src_b,
   output logic [ALUOP_W-1:0]  aluop,
   output logic                illegal,
   output logic                bus_err,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_IMM1 = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_IMM2 = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6);

   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2);

   // Last waiting-cycle count before the limit is reached; the wait that
   // would bring the count to MEM_TIMEOUT is the one that times out.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_t                state_reg, state_next;
   logic [OPCODE_W-1:0]   op_reg, op_next;
   logic [TMO_W-1:0]      tmo_reg, tmo_next;
   logic                  illegal_reg, illegal_next;
   logic                  bus_err_reg, bus_err_next;
   logic                  opcode_illegal;
   logic                  timeout_hit;

   // Any opcode at or above 7 (zero-extended) has no defined behaviour.
   assign opcode_illegal = (32'(opcode) >= 32'd7);

   // A waiting cycle without mem_ready that exhausts the budget.
   assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (tmo_reg == TMO_LAST);

   assign state   = state_reg;
   assign illegal = illegal_reg;
   assign bus_err = bus_err_reg;

   // State, latched opcode, wait counter and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         op_reg      <= '0;
         tmo_reg     <= '0;
         illegal_reg <= 1'b0;
         bus_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         op_reg      <= op_next;
         tmo_reg     <= tmo_next;
         illegal_reg <= illegal_next;
         bus_err_reg <= bus_err_next;
      end
   end

   // Next-state sequencing and per-state datapath strobes.
   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      tmo_next     = '0;
      illegal_next = illegal_reg;
      bus_err_next = bus_err_reg;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      jump         = 1'b0;
      branch       = 1'b0;
      mem_req      = 1'b0;
      memwrite     = 1'b0;
      regwrite     = 1'b0;
      memtoreg     = 1'b0;
      reg_dest     = 1'b0;
      alu_src_b    = 1'b0;
      aluop        = ALU_FUNCT;

      case (state_reg)
         S_IDLE: begin
            state_next = S_FETCH;
         end

         S_FETCH: begin
            mem_req = 1'b1;
            aluop   = ALU_ADD;
            if (mem_ready) begin
               // IR load and PC+2 happen on the completing cycle.
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end else if (timeout_hit) begin
               state_next   = S_HALT;
               bus_err_next = 1'b1;
            end else begin
               tmo_next = tmo_reg + TMO_W'(1);
            end
         end

         S_DECODE: begin
            op_next = opcode;
            if (opcode_illegal) begin
               state_next   = S_HALT;
               illegal_next = 1'b1;
            end else begin
               state_next = S_EXEC;
            end
         end

         S_EXEC: begin
            case (op_reg)
               OP_R: begin
                  aluop      = ALU_FUNCT;
                  state_next = S_WB;
               end
               OP_IMM1, OP_IMM2: begin
                  aluop      = ALU_ADD;
                  alu_src_b  = 1'b1;
                  reg_dest   = 1'b1;
                  state_next = S_WB;
               end
               OP_ST, OP_LD: begin
                  aluop      = ALU_ADD;
                  alu_src_b  = 1'b1;
                  state_next = S_MEM;
               end
               OP_JMP: begin
                  jump       = 1'b1;
                  pc_write   = 1'b1;
                  state_next = S_FETCH;
               end
               OP_BEQ: begin
                  aluop      = ALU_SUB;
                  branch     = 1'b1;
                  pc_write   = zero;
                  state_next = S_FETCH;
               end
               default: begin
                  // Unreachable: DECODE never lets an illegal code through.
                  state_next   = S_HALT;
                  illegal_next = 1'b1;
               end
            endcase
         end

         S_MEM: begin
            mem_req  = 1'b1;
            memwrite = (op_reg == OP_ST);
            if (mem_ready) begin
               state_next = (op_reg == OP_LD) ? S_WB : S_FETCH;
            end else if (timeout_hit) begin
               state_next   = S_HALT;
               bus_err_next = 1'b1;
            end else begin
               tmo_next = tmo_reg + TMO_W'(1);
            end
         end

         S_WB: begin
            regwrite   = 1'b1;
            reg_dest   = (op_reg != OP_R);
            memtoreg   = (op_reg == OP_LD);
            state_next = S_FETCH;
         end

         S_HALT: begin
            state_next = S_HALT;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction sequences, a reference
// model of the instruction flow checked every cycle, and literal spot checks.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic       mem_ready = 1'b0;
   logic       zero = 1'b0;
   logic       ir_write, pc_write, jump, branch, mem_req, memwrite;
   logic       regwrite, memtoreg, reg_dest, alu_src_b;
   logic [1:0] aluop;
   logic       illegal, bus_err;
   logic [2:0] state;

   int n_vec = 0;
   int n_miss = 0;

   multicycle_control #(
      .OPCODE_W(3), .ALUOP_W(2), .MEM_TIMEOUT(15), .TMO_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .zero(zero), .ir_write(ir_write), .pc_write(pc_write), .jump(jump),
      .branch(branch), .mem_req(mem_req), .memwrite(memwrite),
      .regwrite(regwrite), .memtoreg(memtoreg), .reg_dest(reg_dest),
      .alu_src_b(alu_src_b), .aluop(aluop), .illegal(illegal),
      .bus_err(bus_err), .state(state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Phase numbers follow the published state codes; m_wait counts waiting
   // cycles of the current memory request.
   int m_st = 0;
   int m_op = 0;
   int m_wait = 0;
   bit m_ill = 1'b0;
   bit m_berr = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = 0; m_op = 0; m_wait = 0; m_ill = 1'b0; m_berr = 1'b0;
      end else begin
         case (m_st)
            0: m_st = 1;
            1, 4: begin
               if (mem_ready) begin
                  m_wait = 0;
                  if (m_st == 1) m_st = 2;
                  else m_st = (m_op == 4) ? 5 : 1;
               end else begin
                  m_wait = m_wait + 1;
                  if (m_wait == 15) begin
                     m_st = 6; m_berr = 1'b1; m_wait = 0;
                  end
               end
            end
            2: begin
               m_op = int'(opcode);
               if (m_op >= 7) begin m_st = 6; m_ill = 1'b1; end
               else m_st = 3;
            end
            3: begin
               if (m_op <= 2) m_st = 5;
               else if (m_op <= 4) begin m_st = 4; m_wait = 0; end
               else m_st = 1;
            end
            5: m_st = 1;
            default: m_st = 6;
         endcase
      end
   end

   // Packed order: ir_write pc_write jump branch mem_req memwrite regwrite
   // memtoreg reg_dest alu_src_b aluop[1:0] illegal bus_err state[2:0]
   function automatic logic [16:0] model_out(int st, int op, bit rdy, bit z,
                                             bit ill, bit berr);
      bit iw = 0, pw = 0, jp = 0, br = 0, mr = 0, mw = 0, rw = 0, m2r = 0;
      bit rd = 0, asb = 0;
      logic [1:0] ao = 2'd0;
      bit is_r = (op == 0);
      bit is_imm = (op == 1) || (op == 2);
      bit is_mem = (op == 3) || (op == 4);
      if (st == 1) begin
         mr = 1; ao = 2'd1; iw = rdy; pw = rdy;
      end else if (st == 3) begin
         if (is_r) ao = 2'd0;
         else if (is_imm) begin ao = 2'd1; asb = 1; rd = 1; end
         else if (is_mem) begin ao = 2'd1; asb = 1; end
         else if (op == 5) begin jp = 1; pw = 1; end
         else if (op == 6) begin ao = 2'd2; br = 1; pw = z; end
      end else if (st == 4) begin
         mr = 1; mw = (op == 3);
      end else if (st == 5) begin
         rw = 1; rd = !is_r; m2r = (op == 4);
      end
      return {iw, pw, jp, br, mr, mw, rw, m2r, rd, asb, ao, ill, berr, 3'(st)};
   endfunction

   int cyc = 0;

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [16:0] exp_v, act_v;
      cyc = cyc + 1;
      exp_v = model_out(m_st, m_op, mem_ready, zero, m_ill, m_berr);
      act_v = {ir_write, pc_write, jump, branch, mem_req, memwrite, regwrite,
               memtoreg, reg_dest, alu_src_b, aluop, illegal, bus_err, state};
      n_vec = n_vec + 1;
      if (act_v !== exp_v) begin
         n_miss = n_miss + 1;
         $display("FAIL model cyc%0d outputs got %b want %b", cyc, act_v, exp_v);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Hold reset two cycles, release, and confirm IDLE at the next negedge.
   task automatic do_reset();
      rst_n = 1'b0; opcode = 3'd0; mem_ready = 1'b0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_idle", 32'(state), 32'd0);
      $display("reset released: state=%0d", state);
   endtask

   // Advance one clock, apply inputs for the new cycle, check its state.
   task automatic step(input logic [2:0] op, input logic rdy, input logic z,
                       input logic [2:0] exp_st);
      @(posedge clk);
      #1;
      opcode = op; mem_ready = rdy; zero = z;
      @(negedge clk);
      chk("state_seq", 32'(state), 32'(exp_st));
      $display("step op=%0d rdy=%0b zero=%0b state=%0d", op, rdy, z, state);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // R-type, ready tied high: 1,2,3,5,1
      step(3'd0, 1, 0, 3'd1);
      chk("fetch_ir_write", 32'(ir_write), 32'd1);
      chk("fetch_pc_write", 32'(pc_write), 32'd1);
      step(3'd0, 1, 0, 3'd2);
      step(3'd5, 1, 0, 3'd3);
      chk("r_exec_aluop", 32'(aluop), 32'd0);
      chk("r_exec_regwrite", 32'(regwrite), 32'd0);
      step(3'd5, 1, 0, 3'd5);
      chk("r_wb_regwrite", 32'(regwrite), 32'd1);
      chk("r_wb_reg_dest", 32'(reg_dest), 32'd0);
      step(3'd1, 1, 0, 3'd1);

      // Immediate op 001
      step(3'd1, 1, 0, 3'd2);
      step(3'd1, 1, 0, 3'd3);
      chk("imm_alu_src_b", 32'(alu_src_b), 32'd1);
      chk("imm_reg_dest", 32'(reg_dest), 32'd1);
      step(3'd0, 1, 0, 3'd5);
      step(3'd4, 1, 0, 3'd1);

      // Load with three stalled MEM cycles
      step(3'd4, 1, 0, 3'd2);
      step(3'd4, 1, 0, 3'd3);
      step(3'd0, 0, 0, 3'd4);
      step(3'd0, 0, 0, 3'd4);
      step(3'd0, 0, 0, 3'd4);
      step(3'd0, 1, 0, 3'd4);
      chk("ld_mem_memwrite", 32'(memwrite), 32'd0);
      step(3'd0, 1, 0, 3'd5);
      chk("ld_wb_memtoreg", 32'(memtoreg), 32'd1);
      chk("ld_wb_reg_dest", 32'(reg_dest), 32'd1);
      step(3'd3, 1, 0, 3'd1);

      // Store
      step(3'd3, 1, 0, 3'd2);
      step(3'd3, 1, 0, 3'd3);
      step(3'd3, 1, 0, 3'd4);
      chk("st_memwrite", 32'(memwrite), 32'd1);
      step(3'd6, 1, 1, 3'd1);

      // BEQ taken then not taken
      step(3'd6, 1, 1, 3'd2);
      step(3'd6, 1, 1, 3'd3);
      chk("beq_taken_pc_write", 32'(pc_write), 32'd1);
      chk("beq_branch", 32'(branch), 32'd1);
      chk("beq_aluop", 32'(aluop), 32'd2);
      step(3'd6, 1, 0, 3'd1);
      step(3'd6, 1, 0, 3'd2);
      step(3'd6, 1, 0, 3'd3);
      chk("beq_not_taken_pc_write", 32'(pc_write), 32'd0);
      step(3'd5, 1, 0, 3'd1);

      // Jump
      step(3'd5, 1, 0, 3'd2);
      step(3'd5, 1, 0, 3'd3);
      chk("jmp_jump", 32'(jump), 32'd1);
      chk("jmp_pc_write", 32'(pc_write), 32'd1);
      step(3'd7, 1, 0, 3'd1);

      // Illegal opcode parks in HALT
      step(3'd7, 1, 0, 3'd2);
      step(3'd0, 1, 0, 3'd6);
      chk("halt_illegal", 32'(illegal), 32'd1);
      chk("halt_mem_req", 32'(mem_req), 32'd0);
      for (int i = 0; i < 3; i++) step(3'd0, 1, 0, 3'd6);

      // Asynchronous reset in the middle of a store's MEM cycle
      do_reset();
      step(3'd3, 1, 0, 3'd1);
      step(3'd3, 1, 0, 3'd2);
      step(3'd3, 1, 0, 3'd3);
      step(3'd3, 0, 0, 3'd4);
      chk("pre_reset_memwrite", 32'(memwrite), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_memwrite", 32'(memwrite), 32'd0);
      chk("async_mem_req", 32'(mem_req), 32'd0);
      chk("async_state", 32'(state), 32'd0);

      // Fetch timeout: 15 waiting cycles then HALT
      do_reset();
      for (int i = 0; i < 15; i++) step(3'd0, 0, 0, 3'd1);
      step(3'd0, 0, 0, 3'd6);
      chk("tmo_bus_err", 32'(bus_err), 32'd1);
      chk("tmo_mem_req", 32'(mem_req), 32'd0);
      chk("tmo_illegal", 32'(illegal), 32'd0);

      // Ready on the 15th cycle wins over the timeout
      do_reset();
      for (int i = 0; i < 14; i++) step(3'd0, 0, 0, 3'd1);
      step(3'd0, 1, 0, 3'd1);
      chk("tmo_edge_ir_write", 32'(ir_write), 32'd1);
      step(3'd0, 1, 0, 3'd2);
      chk("tmo_edge_bus_err", 32'(bus_err), 32'd0);

      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
